// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller:
// FSM state encoding, IF/ID write codes, opcodes and the rt-usage decoder.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_EXT_STALL  = 2'd3
  } ctrl_state_e;

  localparam logic [2:0] IFID_LOAD  = 3'b111;
  localparam logic [2:0] IFID_HOLD  = 3'b010;
  localparam logic [2:0] IFID_FLUSH = 3'b000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // True when the instruction reads rt as a source operand.
  function automatic logic uses_rt(input logic [5:0] opcode);
    case (opcode)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: uses_rt = 1'b1;
      default:                         uses_rt = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose destination is read
// by the instruction currently in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] id_opcode,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  // $zero never carries a real dependency.
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || ((ex_rt == id_rt) && uses_rt(id_opcode)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/sequencing controller (Mealy FSM) resolving branch flushes,
// external stalls and load-use stalls. Optional counters: HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BRANCH_FLUSH_CYCLES = 1,
  parameter int CNT_W               = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ext_stall_req,
  output logic [2:0]       if_id_write,
  output logic             pc_write,
  output logic             id_ex_bubble,
  output logic [1:0]       ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(BRANCH_FLUSH_CYCLES - 1);

  ctrl_state_e state_q, state_d;
  logic [2:0]  remaining_q, remaining_d;
  logic        load_use;

  hazard_detect u_hazard_detect (
    .id_opcode   (id_opcode),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .load_use    (load_use)
  );

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    if_id_write  = IFID_LOAD;
    pc_write     = 1'b1;
    id_ex_bubble = 1'b0;
    if (ex_branch_taken) begin
      if_id_write  = IFID_FLUSH;
      id_ex_bubble = 1'b1;
      if (BRANCH_FLUSH_CYCLES > 1) begin
        state_d     = ST_FLUSH;
        remaining_d = FLUSH_RELOAD;
      end else begin
        state_d     = ST_RUN;
        remaining_d = 3'd0;
      end
    end else if (state_q == ST_FLUSH) begin
      // Wrong-path instructions are still arriving; load-use is irrelevant here.
      if_id_write  = IFID_FLUSH;
      id_ex_bubble = 1'b1;
      remaining_d  = remaining_q - 3'd1;
      if (remaining_q <= 3'd1) begin
        state_d     = ext_stall_req ? ST_EXT_STALL : ST_RUN;
        remaining_d = 3'd0;
      end
    end else if (ext_stall_req) begin
      if_id_write  = IFID_HOLD;
      pc_write     = 1'b0;
      id_ex_bubble = 1'b1;
      state_d      = ST_EXT_STALL;
    end else if (state_q == ST_LOAD_STALL) begin
      state_d = ST_RUN;
    end else if (load_use) begin
      if_id_write  = IFID_HOLD;
      pc_write     = 1'b0;
      id_ex_bubble = 1'b1;
      state_d      = ST_LOAD_STALL;
    end else begin
      state_d = ST_RUN;
    end
    if (reset) begin
      if_id_write  = IFID_FLUSH;
      pc_write     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  assign ctrl_state = reset ? ST_RUN : state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      remaining_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters; the reset branch keeps reset cycles out of the tally.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((if_id_write == IFID_HOLD) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if ((if_id_write == IFID_FLUSH) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard/sequencing controller for the 5-stage pipeline. Every cycle it decides whether the IF/ID register loads, holds or flushes, whether the PC advances, and whether a bubble enters ID/EX. It resolves load-use hazards, taken-branch flushes and external (memory-busy) stalls by fixed priority. It drives the existing 3-bit IF/ID write code directly.

## Interface
Parameters:
- BRANCH_FLUSH_CYCLES, 1, number of consecutive flush cycles per taken branch (1..7)
- CNT_W, 32, width of performance counters

Ports:
- clock  in  1  pipeline clock, state updates on posedge
- reset  in  1  asynchronous, active-high
- id_opcode  in  6  opcode of instruction in ID
- id_rs  in  5  rs field in ID
- id_rt  in  5  rt field in ID
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  destination (rt) of instruction in EX
- ex_branch_taken  in  1  branch in EX resolved taken this cycle
- ext_stall_req  in  1  data memory busy; hold front end
- if_id_write  out  3  111 load, 010 hold, 000 flush
- pc_write  out  1  PC register enable
- id_ex_bubble  out  1  zero control bits into ID/EX
- ctrl_state  out  2  current FSM state (debug)
- stall_cnt, flush_cnt  out  CNT_W  only with HAZARD_PERF_CNT_EN

## Operation
- FSM states: RUN(0), LOAD_STALL(1), FLUSH(2), EXT_STALL(3).
- Per-cycle priority: branch > external stall > load-use > normal.
- Normal (RUN, no event): if_id_write=111, pc_write=1, id_ex_bubble=0.
- Taken branch (any state): if_id_write=000, pc_write=1, id_ex_bubble=1; if BRANCH_FLUSH_CYCLES>1, go FLUSH with remaining=BRANCH_FLUSH_CYCLES-1, else RUN. A new taken branch in FLUSH reloads remaining.
- FLUSH: outputs as taken branch; decrement remaining; at remaining==1 exit to EXT_STALL if ext_stall_req, else RUN. Load-use check masked.
- ext_stall_req (no branch): if_id_write=010, pc_write=0, id_ex_bubble=1; state EXT_STALL while asserted; returns to RUN the cycle after deassertion.
- Load-use hazard: ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (ex_rt==id_rt && uses_rt(id_opcode))). Response: 010, pc_write=0, bubble=1; next state LOAD_STALL.
- LOAD_STALL: lasts exactly one cycle, hazard check masked (EX holds bubble); outputs normal 111/1/0; next RUN. Branch/ext stall still take priority.
- uses_rt true for opcodes 000000 (R-type), 000100 (beq), 000101 (bne), 101011 (sw).
- Code 010 never coincides with pc_write=1; code 000 always coincides with id_ex_bubble=1.

## Timing
- Outputs are combinational from registered state plus current inputs (Mealy); zero-cycle response to hazards.
- State/counters update on posedge clock.
- While reset high: state=RUN, remaining=0, counters=0, outputs forced to if_id_write=000, pc_write=0, id_ex_bubble=1, ctrl_state=0 regardless of inputs.
- Reset asserted mid-FLUSH or mid-stall abandons it; first cycle after release is RUN.
- Load-use stall costs exactly 1 cycle; branch costs BRANCH_FLUSH_CYCLES cycles.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cnt increments each cycle with if_id_write==010; flush_cnt each cycle with 000 (not during reset); both saturate at all-ones; ports present.
- Undefined: counters and ports absent; control behaviour identical.

## Structure
- Package pipe_ctrl_pkg: state enum, IF_ID code constants (IFID_LOAD=3'b111, IFID_HOLD=3'b010, IFID_FLUSH=3'b000), opcode constants, uses_rt function.
- Sub-module hazard_detect: pure combinational load-use comparator; FSM and counters in top.

## Test plan
- Reset held with ex_branch_taken=1 -> 000/0/1, ctrl_state=0; release, idle inputs -> 111/1/0.
- lw $2 in EX (ex_mem_read=1, ex_rt=2), add with id_rs=2 in ID -> one cycle 010/0/1, then 111/1/0 with LOAD_STALL, then RUN.
- ex_rt=0 with ex_mem_read=1 and id_rs=0 -> no stall; ex_rt=5 matches id_rt, opcode lw (100011) -> no stall.
- BRANCH_FLUSH_CYCLES=2, branch taken -> two cycles 000/1/1; second branch during FLUSH -> two more cycles.
- ext_stall_req high 3 cycles while load-use present -> 3 cycles 010/0/1 in EXT_STALL; branch during it -> 000 that cycle.
- With HAZARD_PERF_CNT_EN: above sequence -> stall_cnt and flush_cnt match cycle counts exactly; CNT_W=4 saturates at 15.
